// File: rtl/aes_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// aes_pkg: shared widths and loader state encoding for the AES datapath.
// Revision: 1.0
// ----------------------------------------------------------------------------
package aes_pkg;

    localparam int BYTE_W     = 8;
    localparam int WORD_W     = 32;
    localparam int SENTENCE_W = 128;

    localparam logic [1:0] LOAD  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

endpackage
`default_nettype wire

// File: rtl/aes_word_serializer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// aes_word_serializer: 4-word ciphertext buffer drained over valid/ready.
// Revision: 1.0
// ----------------------------------------------------------------------------
module aes_word_serializer #(
    parameter int WORD     = 32,
    parameter int SENTENCE = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [SENTENCE-1:0] data,
    input  logic                out_ready,
    output logic [WORD-1:0]     out_word,
    output logic                out_valid,
    output logic                last
);

    logic [SENTENCE-1:0] buffer;
    logic [1:0]          idx;
    logic                valid;
    logic [WORD-1:0]     word_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            buffer <= '0;
            idx    <= 2'd0;
            valid  <= 1'b0;
        end else if (load) begin
            buffer <= data;
            idx    <= 2'd0;
            valid  <= 1'b1;
        end else if (valid && out_ready) begin
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
                valid <= 1'b0;
            end
        end
    end

    // First-loaded word is the most significant one.
    always_comb begin
        word_sel = '0;
        case (idx)
            2'd0:    word_sel = buffer[SENTENCE-1 -: WORD];
            2'd1:    word_sel = buffer[3*WORD-1 -: WORD];
            2'd2:    word_sel = buffer[2*WORD-1 -: WORD];
            default: word_sel = buffer[WORD-1:0];
        endcase
    end

    assign out_word  = valid ? word_sel : '0;
    assign out_valid = valid;
    assign last      = valid && out_ready && (idx == 2'd3);

endmodule
`default_nettype wire

// File: rtl/aes_word_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// aes_word_loader: collects key/plaintext words, launches the AES core and
// streams the ciphertext back out. Optional macro: AES_LOADER_WATCHDOG_EN.
// Revision: 1.0
// ----------------------------------------------------------------------------
module aes_word_loader
    import aes_pkg::*;
#(
    parameter int WORD     = 32,
    parameter int SENTENCE = 128,
    parameter int TIMEOUT  = 31
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [WORD-1:0]     In_Word,
    input  logic                In_Valid,
    input  logic                In_Is_Key,
    output logic                In_Ready,
    output logic [SENTENCE-1:0] Plain_Text,
    output logic [SENTENCE-1:0] Key,
    output logic                Start,
    input  logic                Done,
    input  logic [SENTENCE-1:0] Cipher_Text,
    output logic [WORD-1:0]     Out_Word,
    output logic                Out_Valid,
    input  logic                Out_Ready,
    output logic                Busy,
    output logic                Error
);

    if (SENTENCE != 4 * WORD) begin : g_bad_width
        $error("aes_word_loader: SENTENCE must equal 4*WORD");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("aes_word_loader: TIMEOUT must be at least 1");
    end

    logic [1:0]          state;
    logic [2:0]          pt_cnt;
    logic [1:0]          key_cnt;
    logic                key_ok;
    logic [SENTENCE-1:0] key_q;
    logic [SENTENCE-1:0] pt_q;

    logic                load_ready;
    logic                key_acc;
    logic                pt_acc;
    logic [2:0]          pt_cnt_nxt;
    logic [1:0]          key_cnt_nxt;
    logic                key_ok_nxt;
    logic                launch;
    logic                done_hit;
    logic                timeout;
    logic                ser_valid;
    logic                ser_last;
    logic [WORD-1:0]     ser_word;

    assign load_ready = (state == LOAD) && (In_Is_Key || (pt_cnt != 3'd4));
    assign key_acc    = In_Valid && load_ready && In_Is_Key;
    assign pt_acc     = In_Valid && load_ready && !In_Is_Key;
    assign done_hit   = (state == WAIT) && Done;

    always_comb begin
        pt_cnt_nxt  = pt_cnt + {2'b00, pt_acc};
        key_cnt_nxt = key_cnt + {1'b0, key_acc};
        key_ok_nxt  = key_ok;
        if (key_acc && (key_cnt == 2'd0)) begin
            key_ok_nxt = 1'b0;
        end
        if (key_acc && (key_cnt == 2'd3)) begin
            key_ok_nxt = 1'b1;
        end
    end

    // Judged on the values being registered this edge, so START directly
    // follows the cycle that accepts the completing word.
    assign launch = (state == LOAD) && (pt_cnt_nxt == 3'd4) && key_ok_nxt
                    && (key_cnt_nxt == 2'd0);

`ifdef AES_LOADER_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            err_q;

    assign timeout = (state == WAIT) && !Done && (wd_cnt == WD_W'(TIMEOUT - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            err_q  <= timeout;
            wd_cnt <= (state == WAIT) ? wd_cnt + 1'b1 : '0;
        end
    end

    assign Error = !RST && err_q;
`else
    assign timeout = 1'b0;
    assign Error   = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= LOAD;
            pt_cnt  <= 3'd0;
            key_cnt <= 2'd0;
            key_ok  <= 1'b0;
            key_q   <= '0;
            pt_q    <= '0;
        end else begin
            if (key_acc) begin
                key_q <= {key_q[SENTENCE-WORD-1:0], In_Word};
            end
            if (pt_acc) begin
                pt_q <= {pt_q[SENTENCE-WORD-1:0], In_Word};
            end
            key_cnt <= key_cnt_nxt;
            key_ok  <= key_ok_nxt;
            pt_cnt  <= (done_hit || timeout) ? 3'd0 : pt_cnt_nxt;
            case (state)
                LOAD:    if (launch) state <= START;
                START:   state <= WAIT;
                WAIT: begin
                    if (done_hit) begin
                        state <= DRAIN;
                    end else if (timeout) begin
                        state <= LOAD;
                    end
                end
                DRAIN:   if (ser_last) state <= LOAD;
                default: state <= LOAD;
            endcase
        end
    end

    aes_word_serializer #(
        .WORD     (WORD),
        .SENTENCE (SENTENCE)
    ) u_serializer (
        .clk       (CLK),
        .rst       (RST),
        .load      (done_hit),
        .data      (Cipher_Text),
        .out_ready (Out_Ready),
        .out_word  (ser_word),
        .out_valid (ser_valid),
        .last      (ser_last)
    );

    assign In_Ready   = !RST && load_ready;
    assign Start      = !RST && (state == START);
    assign Busy       = !RST && (state != LOAD);
    assign Out_Valid  = !RST && ser_valid;
    assign Out_Word   = RST ? '0 : ser_word;
    assign Key        = key_q;
    assign Plain_Text = pt_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_word_loader.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_aes_word_loader: randomized bench with a stub cipher and block-level model.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_aes_word_loader;

    localparam int WORD     = 32;
    localparam int SENTENCE = 128;
    localparam int TIMEOUT  = 31;

    logic                CLK = 1'b0;
    logic                RST;
    logic [WORD-1:0]     In_Word;
    logic                In_Valid;
    logic                In_Is_Key;
    logic                In_Ready;
    logic [SENTENCE-1:0] Plain_Text;
    logic [SENTENCE-1:0] Key;
    logic                Start;
    logic                Done;
    logic [SENTENCE-1:0] Cipher_Text;
    logic [WORD-1:0]     Out_Word;
    logic                Out_Valid;
    logic                Out_Ready;
    logic                Busy;
    logic                Error;

    aes_word_loader #(
        .WORD     (WORD),
        .SENTENCE (SENTENCE),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .In_Word     (In_Word),
        .In_Valid    (In_Valid),
        .In_Is_Key   (In_Is_Key),
        .In_Ready    (In_Ready),
        .Plain_Text  (Plain_Text),
        .Key         (Key),
        .Start       (Start),
        .Done        (Done),
        .Cipher_Text (Cipher_Text),
        .Out_Word    (Out_Word),
        .Out_Valid   (Out_Valid),
        .Out_Ready   (Out_Ready),
        .Busy        (Busy),
        .Error       (Error)
    );

    always #5 CLK = ~CLK;

    int              n_tests = 0;
    int              n_fail  = 0;
    int              cyc     = 0;
    int              n_start = 0;
    int              start_cyc = 0;
    int              done_cyc  = 0;
    int              ciph_cnt  = 0;
    int              ciph_lat  = 1;
    bit              ciph_en   = 1'b1;
    bit              spur_en   = 1'b0;
    logic [127:0]    ciph_ct;
    logic [127:0]    cur_key;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] FIPS_CT  = 128'h3925841d02dc09fbdc118597196a0b32;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Stand-in cipher: the real vector for the FIPS-197 example, a keyed mix otherwise.
    function automatic logic [127:0] cipher_fn(input logic [127:0] k, input logic [127:0] p);
        if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
        return p ^ {k[63:0], k[127:64]} ^ 128'hc3c3_a5a5_0f0f_9696_3c3c_5a5a_f0f0_6969;
    endfunction

    function automatic logic [31:0] word_of(input logic [127:0] s, input int i);
        return s[127 - 32*i -: 32];
    endfunction

    // One clock; the stub cipher reacts to Start and answers after ciph_lat cycles.
    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
        Done        = 1'b0;
        Cipher_Text = {$urandom, $urandom, $urandom, $urandom};
        if (ciph_cnt > 0) begin
            ciph_cnt--;
            if (ciph_cnt == 0) begin
                Done        = 1'b1;
                Cipher_Text = ciph_ct;
                done_cyc    = cyc;
            end
        end
        if (Start === 1'b1) begin
            n_start++;
            start_cyc = cyc;
            if (ciph_en) begin
                ciph_cnt = ciph_lat;
                ciph_ct  = cipher_fn(Key, Plain_Text);
            end
        end
        if (spur_en && ciph_cnt == 0 && !Done && (Busy === 1'b0 || Out_Valid === 1'b1)
            && ($urandom % 4 == 0)) begin
            Done = 1'b1;
        end
    endtask

    task automatic do_reset();
        ciph_cnt = 0;
        In_Valid = 1'b0;
        Done     = 1'b0;
        RST      = 1'b1;
        #1;
        check("rst_outs", {In_Ready, Out_Valid, Busy, Start, Error}, 5'b0);
        begin
            bit s;
            s = spur_en;
            spur_en = 1'b0;
            tick();
            spur_en = s;
        end
        RST       = 1'b0;
        Done      = 1'b0;
        In_Is_Key = 1'b0;
        #1;
        check("post_rst_ctrl", {In_Ready, Out_Valid, Busy, Start, Error}, 5'b10000);
        check("post_rst_key", Key, 128'd0);
        check("post_rst_pt", Plain_Text, 128'd0);
    endtask

    task automatic send(input bit is_key, input logic [31:0] w);
        int k;
        In_Valid  = 1'b1;
        In_Is_Key = is_key;
        In_Word   = w;
        for (k = 0; k < 20; k++) begin
            #1;
            if (In_Ready === 1'b1) break;
            tick();
        end
        if (k == 20) check("send_timeout", In_Ready, 1'b1);
        tick();
        In_Valid = 1'b0;
    endtask

    task automatic drain(input int mode, input logic [127:0] exp_ct,
                         input logic [127:0] ek, input logic [127:0] ep);
        int  n  = 0;
        int  fv = 0;
        int  lx = 0;
        bit  seen = 1'b0;
        bit  xfer;
        for (int c = 0; c < 200 && n < 4; c++) begin
            case (mode)
                0:       Out_Ready = 1'b1;
                1:       Out_Ready = (c % 4 == 0) || (c % 4 == 3);
                default: Out_Ready = $urandom % 2;
            endcase
            #1;
            xfer = 1'b0;
            if (seen) check("ov_hold", Out_Valid, 1'b1);
            if (Out_Valid === 1'b1) begin
                if (!seen) begin
                    seen = 1'b1;
                    fv   = cyc;
                    check("ov_latency", cyc, done_cyc + 1);
                    check("key_held", Key, ek);
                    check("pt_held", Plain_Text, ep);
                end
                check("out_word", Out_Word, word_of(exp_ct, n));
                check("in_ready_drain", In_Ready, 1'b0);
                xfer = Out_Ready;
                if (xfer) lx = cyc;
            end else begin
                check("in_ready_wait", In_Ready, 1'b0);
            end
            tick();
            if (xfer) n++;
        end
        check("xfer_count", n, 4);
        if (mode == 0) check("b2b_span", lx - fv, 3);
        Out_Ready = 1'b0;
        In_Is_Key = 1'b0;
        #1;
        check("drain_exit", {Out_Valid, Busy, In_Ready}, 3'b001);
    endtask

    // abort: 0 full block, 1 return in START cycle with no Done, 2 reset mid-DRAIN
    task automatic run_block(input bit new_key, input int order, input int out_mode,
                             input bit fixed, input int abort, input int lat);
        logic [31:0]  kw [4];
        logic [31:0]  pw [4];
        logic [127:0] ek, ep, tk, tp;
        int ki = 0, pi = 0, s0, total;
        bit pick;
        tk = fixed ? FIPS_KEY : {$urandom, $urandom, $urandom, $urandom};
        tp = fixed ? FIPS_PT  : {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 4; i++) begin
            kw[i] = word_of(tk, i);
            pw[i] = word_of(tp, i);
        end
        ek       = new_key ? tk : cur_key;
        ep       = tp;
        ciph_en  = (abort != 1);
        ciph_lat = lat;
        s0       = n_start;
        total    = new_key ? 8 : 4;
        for (int t = 0; t < total; t++) begin
            case (order)
                0:       pick = 1'b1;
                1:       pick = (t % 2 == 0);
                default: pick = (t == 0) ? 1'b1 : bit'($urandom % 2);
            endcase
            if (new_key && ki < 4 && (pi == 4 || pick)) begin
                send(1'b1, kw[ki]);
                ki++;
            end else begin
                send(1'b0, pw[pi]);
                pi++;
            end
            check("start", Start, (t == total - 1) ? 1'b1 : 1'b0);
        end
        check("key_at_start", Key, ek);
        check("pt_at_start", Plain_Text, ep);
        check("start_pulses", n_start - s0, 1);
        cur_key = ek;
        if (abort == 1) return;
        if (abort == 2) begin
            logic [31:0] w0;
            int k;
            Out_Ready = 1'b0;
            for (k = 0; k < 40; k++) begin
                #1;
                if (Out_Valid === 1'b1) break;
                tick();
            end
            check("stall_valid", Out_Valid, 1'b1);
            w0 = word_of(cipher_fn(ek, ep), 0);
            for (int j = 0; j < 2; j++) begin
                check("stall_word", Out_Word, w0);
                tick();
            end
            do_reset();
            return;
        end
        drain(out_mode, cipher_fn(ek, ep), ek, ep);
        check("single_start", n_start - s0, 1);
    endtask

    // After reset the key is gone: plaintext alone must not launch.
    task automatic post_reset_recover();
        logic [31:0]  pw [4];
        logic [31:0]  kw [4];
        logic [127:0] ek, ep;
        int s0;
        ciph_en  = 1'b1;
        ciph_lat = $urandom_range(1, 12);
        s0 = n_start;
        for (int i = 0; i < 4; i++) begin
            pw[i] = $urandom;
            send(1'b0, pw[i]);
            check("nokey_idle", {Start, Busy}, 2'b00);
        end
        ep = {pw[0], pw[1], pw[2], pw[3]};
        In_Valid  = 1'b1;
        In_Is_Key = 1'b0;
        In_Word   = $urandom;
        #1;
        check("pt_full_rdy", In_Ready, 1'b0);
        In_Is_Key = 1'b1;
        #1;
        check("key_rdy_full", In_Ready, 1'b1);
        In_Valid = 1'b0;
        Done     = 1'b1;
        tick();
        Done = 1'b0;
        #1;
        check("stray_done", {Out_Valid, Busy}, 2'b00);
        for (int i = 0; i < 4; i++) begin
            kw[i] = $urandom;
            send(1'b1, kw[i]);
            check("rekey_start", Start, (i == 3) ? 1'b1 : 1'b0);
        end
        ek = {kw[0], kw[1], kw[2], kw[3]};
        check("rekey_key", Key, ek);
        check("rekey_pt", Plain_Text, ep);
        drain(0, cipher_fn(ek, ep), ek, ep);
        check("rekey_pulses", n_start - s0, 1);
        cur_key = ek;
    endtask

    initial begin
        In_Word     = '0;
        In_Valid    = 1'b0;
        In_Is_Key   = 1'b0;
        Done        = 1'b0;
        Cipher_Text = '0;
        Out_Ready   = 1'b0;
        RST         = 1'b1;
        cur_key     = '0;
        tick();
        do_reset();

        run_block(1'b1, 0, 0, 1'b1, 0, 1);
        run_block(1'b1, 1, 2, 1'b0, 0, $urandom_range(1, 12));
        run_block(1'b0, 0, 1, 1'b0, 0, $urandom_range(1, 12));
        spur_en = 1'b1;
        for (int r = 0; r < 6; r++) begin
            run_block(bit'($urandom % 2), 2, int'($urandom % 3), 1'b0, 0,
                      $urandom_range(1, 12));
        end

        run_block(1'b1, 0, 0, 1'b0, 1, 1);
        for (int j = 0; j < 3; j++) begin
            tick();
            check("wait_busy", {Busy, Out_Valid}, 2'b10);
        end
        do_reset();
        post_reset_recover();

        run_block(1'b1, 2, 0, 1'b0, 2, $urandom_range(1, 12));
        post_reset_recover();

        spur_en = 1'b0;
`ifdef AES_LOADER_WATCHDOG_EN
        begin
            int sc;
            run_block(1'b1, 0, 0, 1'b0, 1, 1);
            sc = start_cyc;
            for (int c = 0; c < TIMEOUT + 4; c++) begin
                tick();
                check("wd_no_ov", Out_Valid, 1'b0);
                if (cyc == sc + 1 + TIMEOUT) begin
                    check("wd_error", Error, 1'b1);
                    check("wd_load", Busy, 1'b0);
                end else begin
                    check("wd_quiet", Error, 1'b0);
                end
            end
            run_block(1'b0, 0, 0, 1'b0, 0, $urandom_range(1, 12));
        end
`else
        run_block(1'b1, 0, 0, 1'b0, 1, 1);
        for (int c = 0; c < 3 * TIMEOUT; c++) begin
            tick();
            check("wait_forever", {Busy, Error, Out_Valid}, 3'b100);
        end
        do_reset();
        post_reset_recover();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
